key_onehot_capture: RTL and testbench

//  Front end for encoder_4x2: turns 4 raw pushbuttons into clean one-hot codes.
//  - Synchronises and debounces each button, then captures one press per key.
//  - Presents the captured key as a one-hot word on a valid/ready handshake.
//  - w_out is only ever one-hot or 4'b0000, so the encoder never sees an invalid input.

---
 rtl/key_onehot_capture.sv | 140 ++++++++++++++
 tb/tb_key_onehot_capture.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_onehot_capture.sv
// Pushbutton front end: synchronise, debounce and capture one key press.
// Presents the captured key as a one-hot word on a valid/ready handshake.
module key_onehot_capture #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] btn_raw,
    output logic [3:0] w_out,
    output logic       w_valid,
    input  logic       w_ready,
    output logic       multi_err
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        WAIT_REL
    } state_t;

    logic [3:0][SYNC_STAGES-1:0] sync_q, sync_d;
    logic [3:0]                  sync_s;
    logic [3:0][CW-1:0]          cnt_q, cnt_d;
    logic [3:0]                  deb_q, deb_d;
    logic [3:0]                  deb_dly_q, deb_dly_d;
    logic [3:0]                  rise;
    logic                        single;
    state_t                      state_q, state_d;
    logic [3:0]                  w_out_q, w_out_d;
    logic                        w_valid_q, w_valid_d;
    logic                        multi_err_q, multi_err_d;

    // Shift each raw button into its own synchroniser chain.
    always_comb begin
        sync_d = sync_q;
        for (int i = 0; i < 4; i++) begin
            sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], btn_raw[i]};
            sync_s[i] = sync_q[i][SYNC_STAGES-1];
        end
    end

    // Flip a debounced bit only after a full run of disagreeing cycles.
    always_comb begin
        cnt_d     = '0;
        deb_d     = deb_q;
        deb_dly_d = deb_q;
        for (int i = 0; i < 4; i++) begin
            if (sync_s[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    deb_d[i] = ~deb_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end
    end

    // Edge detect and "exactly one key down" test on the debounced word.
    always_comb begin
        rise   = deb_q & ~deb_dly_q;
        single = (deb_q != 4'd0) && ((deb_q & (deb_q - 4'd1)) == 4'd0);
    end

    // Capture FSM: take one clean press, hold it, then wait for full release.
    always_comb begin
        state_d     = state_q;
        w_out_d     = w_out_q;
        w_valid_d   = w_valid_q;
        multi_err_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|rise) begin
                    if (single) begin
                        w_out_d   = deb_q;
                        w_valid_d = 1'b1;
                        state_d   = HOLD;
                    end else begin
                        multi_err_d = 1'b1;
                        state_d     = WAIT_REL;
                    end
                end
            end
            HOLD: begin
                if (w_valid_q && w_ready) begin
                    w_out_d   = 4'd0;
                    w_valid_d = 1'b0;
                    state_d   = WAIT_REL;
                end
            end
            WAIT_REL: begin
                if (deb_q == 4'd0) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Synchroniser and debounce state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '0;
            cnt_q     <= '0;
            deb_q     <= '0;
            deb_dly_q <= '0;
        end else begin
            sync_q    <= sync_d;
            cnt_q     <= cnt_d;
            deb_q     <= deb_d;
            deb_dly_q <= deb_dly_d;
        end
    end

    // FSM state and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            w_out_q     <= 4'd0;
            w_valid_q   <= 1'b0;
            multi_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            w_out_q     <= w_out_d;
            w_valid_q   <= w_valid_d;
            multi_err_q <= multi_err_d;
        end
    end

    assign w_out     = w_out_q;
    assign w_valid   = w_valid_q;
    assign multi_err = multi_err_q;

endmodule

// File: tb/tb_key_onehot_capture.sv
// Bench for key_onehot_capture with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
// Expected captures are queued at stimulus time and popped on each accept.
module tb_key_onehot_capture;

    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int LAT  = 1 + SYNC + DEB;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] btn_raw;
    logic [3:0] w_out;
    logic       w_valid;
    logic       w_ready;
    logic       multi_err;

    int checks = 0;
    int errors = 0;
    int n_acc = 0;
    int n_merr = 0;
    int n_valid_cyc = 0;
    logic [3:0] exp_q[$];
    logic [3:0] sb_exp;

    key_onehot_capture #(
        .SYNC_STAGES(SYNC),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .btn_raw(btn_raw),
        .w_out(w_out),
        .w_valid(w_valid),
        .w_ready(w_ready),
        .multi_err(multi_err)
    );

    always #5 clk = ~clk;

    // Mid-cycle monitor: output legality, event counts and scoreboard pops.
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if (!$onehot0(w_out) || (!w_valid && w_out !== 4'd0)) begin
                errors++;
                $display("FAIL w_out_legal w_out=%b w_valid=%b required one-hot while valid else 0000",
                         w_out, w_valid);
            end
            if (multi_err) n_merr++;
            if (w_valid) n_valid_cyc++;
            if (w_valid && w_ready) begin
                n_acc++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_capture w_out=%b required no capture", w_out);
                end else begin
                    sb_exp = exp_q.pop_front();
                    if (w_out !== sb_exp) begin
                        errors++;
                        $display("FAIL capture_value w_out=%b required %b", w_out, sb_exp);
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (n < 50) begin
            @(posedge clk);
            #1;
            n++;
            if (w_valid) break;
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        btn_raw = 4'd0;
        w_ready = 1'b0;
        step(2);
        checks++;
        if (w_out !== 4'd0 || w_valid !== 1'b0 || multi_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs w_out=%b w_valid=%b multi_err=%b required 0000 0 0",
                     w_out, w_valid, multi_err);
        end
        rst_n = 1'b1;
        step(3);
        checks++;
        if (w_out !== 4'd0 || w_valid !== 1'b0 || multi_err !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle w_out=%b w_valid=%b multi_err=%b required 0000 0 0",
                     w_out, w_valid, multi_err);
        end
    endtask

    task automatic test_latency();
        int n;
        int a0;
        a0 = n_acc;
        w_ready = 1'b1;
        btn_raw = 4'b0100;
        exp_q.push_back(4'b0100);
        wait_valid(n);
        checks++;
        if (n != LAT) begin
            errors++;
            $display("FAIL latency edges=%0d required %0d", n, LAT);
        end
        checks++;
        if (w_out !== 4'b0100) begin
            errors++;
            $display("FAIL latency_value w_out=%b required 0100", w_out);
        end
        step(1);
        checks++;
        if (w_valid !== 1'b0 || w_out !== 4'd0) begin
            errors++;
            $display("FAIL accept_clear w_valid=%b w_out=%b required 0 0000", w_valid, w_out);
        end
        checks++;
        if (n_acc - a0 != 1) begin
            errors++;
            $display("FAIL latency_count accepts=%0d required 1", n_acc - a0);
        end
        btn_raw = 4'd0;
        step(15);
    endtask

    task automatic test_glitch();
        int a0;
        int v0;
        int m0;
        a0 = n_acc;
        v0 = n_valid_cyc;
        m0 = n_merr;
        w_ready = 1'b1;
        btn_raw = 4'b0001;
        step(3);
        btn_raw = 4'd0;
        step(15);
        checks++;
        if (n_valid_cyc != v0 || n_merr != m0) begin
            errors++;
            $display("FAIL short_glitch valid_cycles=%0d merr=%0d required 0 0",
                     n_valid_cyc - v0, n_merr - m0);
        end
        exp_q.push_back(4'b0001);
        btn_raw = 4'b0001;
        step(5);
        btn_raw = 4'd0;
        step(20);
        checks++;
        if (n_acc - a0 != 1) begin
            errors++;
            $display("FAIL long_pulse accepts=%0d required 1", n_acc - a0);
        end
    endtask

    task automatic test_multi();
        int a0;
        int v0;
        int m0;
        a0 = n_acc;
        v0 = n_valid_cyc;
        m0 = n_merr;
        w_ready = 1'b1;
        btn_raw = 4'b1010;
        step(15);
        checks++;
        if (n_merr - m0 != 1) begin
            errors++;
            $display("FAIL multi_err_pulse cycles=%0d required 1", n_merr - m0);
        end
        checks++;
        if (n_valid_cyc != v0) begin
            errors++;
            $display("FAIL multi_no_valid valid_cycles=%0d required 0", n_valid_cyc - v0);
        end
        btn_raw = 4'd0;
        step(15);
        exp_q.push_back(4'b1000);
        btn_raw = 4'b1000;
        step(15);
        checks++;
        if (n_acc - a0 != 1) begin
            errors++;
            $display("FAIL multi_recover accepts=%0d required 1", n_acc - a0);
        end
        btn_raw = 4'd0;
        step(15);
    endtask

    task automatic test_hold();
        int a0;
        int m0;
        int v1;
        m0 = n_merr;
        w_ready = 1'b0;
        exp_q.push_back(4'b0010);
        btn_raw = 4'b0010;
        step(10);
        btn_raw = 4'b0011;
        step(20);
        checks++;
        if (w_valid !== 1'b1 || w_out !== 4'b0010) begin
            errors++;
            $display("FAIL hold_stable w_valid=%b w_out=%b required 1 0010", w_valid, w_out);
        end
        btn_raw = 4'b0001;
        step(10);
        checks++;
        if (w_valid !== 1'b1 || w_out !== 4'b0010) begin
            errors++;
            $display("FAIL hold_after_release w_valid=%b w_out=%b required 1 0010",
                     w_valid, w_out);
        end
        checks++;
        if (n_merr != m0) begin
            errors++;
            $display("FAIL hold_no_merr cycles=%0d required 0", n_merr - m0);
        end
        a0 = n_acc;
        w_ready = 1'b1;
        step(1);
        checks++;
        if (w_valid !== 1'b0 || n_acc - a0 != 1) begin
            errors++;
            $display("FAIL hold_accept w_valid=%b accepts=%0d required 0 1", w_valid, n_acc - a0);
        end
        v1 = n_valid_cyc;
        step(20);
        checks++;
        if (n_valid_cyc != v1) begin
            errors++;
            $display("FAIL wait_release valid_cycles=%0d required 0", n_valid_cyc - v1);
        end
        btn_raw = 4'd0;
        step(15);
    endtask

    task automatic test_reset_mid();
        int n;
        w_ready = 1'b0;
        btn_raw = 4'b0001;
        wait_valid(n);
        checks++;
        if (w_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_valid w_valid=%b required 1", w_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (w_valid !== 1'b0 || w_out !== 4'd0) begin
            errors++;
            $display("FAIL async_reset w_valid=%b w_out=%b required 0 0000", w_valid, w_out);
        end
        step(2);
        rst_n = 1'b1;
        exp_q.push_back(4'b0001);
        w_ready = 1'b1;
        wait_valid(n);
        checks++;
        if (n != LAT || w_out !== 4'b0001) begin
            errors++;
            $display("FAIL recapture edges=%0d w_out=%b required %0d 0001", n, w_out, LAT);
        end
        step(1);
        btn_raw = 4'd0;
        step(15);
    endtask

    task automatic test_bounce();
        int a0;
        a0 = n_acc;
        w_ready = 1'b1;
        exp_q.push_back(4'b0100);
        for (int i = 0; i < 15; i++) begin
            btn_raw = (i % 2 == 0) ? 4'b0100 : 4'b0000;
            step(2);
        end
        btn_raw = 4'b0100;
        step(20);
        checks++;
        if (n_acc - a0 != 1) begin
            errors++;
            $display("FAIL bounce_single accepts=%0d required 1", n_acc - a0);
        end
        btn_raw = 4'd0;
        step(15);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain pending=%0d required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_glitch();
        test_multi();
        test_hold();
        test_reset_mid();
        test_bounce();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
